// File: rtl/prco_lmem_ctrl.sv
// prco_lmem_ctrl: single-port initiator for the PRCO local memory.
// It captures fetch and load/store request strobes into one pending slot per
// port and serves them one at a time, with data taking priority over fetch.
// Each access drives one enable cycle (ISSUE), then waits for the matching
// completion strobe (WAIT), then returns the word with a one-cycle pulse (RESP).
// Optional feature macro: PRCO_LMEM_CTRL_TIMEOUT_EN compiles in a WAIT watchdog
// that aborts the access and pulses q_err after P_TIMEOUT cycles.
module prco_lmem_ctrl #(
    parameter int unsigned P_TIMEOUT = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fetch_req,
    input  logic [15:0] i_fetch_addr,
    output logic        q_fetch_rdy,
    output logic        q_fetch_valid,
    output logic [15:0] q_fetch_instr,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [15:0] i_data_addr,
    input  logic [15:0] i_data_wdata,
    output logic        q_data_rdy,
    output logic        q_data_done,
    output logic [15:0] q_data_rdata,
    output logic        q_err,
    output logic        q_busy,
    output logic        q_ce_fetch,
    output logic        q_ce_alu,
    output logic        q_mem_we,
    output logic [15:0] q_mem_addr,
    output logic [15:0] q_mem_dina,
    input  logic        i_ce_dec,
    input  logic        i_ce_reg,
    input  logic [15:0] i_mem_douta
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (P_TIMEOUT < 2 || P_TIMEOUT > 255) begin : g_bad_timeout
        $error("prco_lmem_ctrl: P_TIMEOUT must be in 2..255");
    end

    state_t      state_r;
    state_t      state_s;
    logic        sel_data_r;      // current access belongs to the data port
    logic        sel_data_s;
    logic        take_s;          // a pending entry is selected on this edge
    logic        match_s;         // matching completion strobe seen in WAIT
    logic        capture_s;       // read word is captured on this edge
    logic        timeout_s;       // watchdog expires on this edge
    logic        err_s;

    logic [15:0] fetch_addr_r;
    logic        data_we_r;
    logic [15:0] data_addr_r;
    logic [15:0] data_wdata_r;

`ifdef PRCO_LMEM_CTRL_TIMEOUT_EN
    logic [7:0]  wait_cnt_r;

    // WAIT watchdog: held at zero outside WAIT, so it starts from zero on entry.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    // The limit is reached on the P_TIMEOUT-th WAIT edge without a match.
    assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == 8'(P_TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and selection logic; data is always preferred over fetch.
    always_comb begin
        state_s    = state_r;
        sel_data_s = sel_data_r;
        take_s     = 1'b0;
        match_s    = 1'b0;
        capture_s  = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!q_data_rdy) begin
                    state_s    = ST_ISSUE;
                    sel_data_s = 1'b1;
                    take_s     = 1'b1;
                end else if (!q_fetch_rdy) begin
                    state_s    = ST_ISSUE;
                    sel_data_s = 1'b0;
                    take_s     = 1'b1;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                match_s = sel_data_r ? i_ce_reg : i_ce_dec;
                if (match_s) begin
                    state_s   = ST_RESP;
                    capture_s = 1'b1;
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and record of which port owns the current access.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            sel_data_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            sel_data_r <= sel_data_s;
        end
    end

    // Fetch pending slot: freed when selected, filled by a strobe while free.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q_fetch_rdy  <= 1'b1;
            fetch_addr_r <= 16'h0000;
        end else if (take_s && !sel_data_s) begin
            q_fetch_rdy  <= 1'b1;
        end else if (i_fetch_req && q_fetch_rdy) begin
            q_fetch_rdy  <= 1'b0;
            fetch_addr_r <= i_fetch_addr;
        end
    end

    // Data pending slot: same discipline, also holding we and write data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q_data_rdy   <= 1'b1;
            data_we_r    <= 1'b0;
            data_addr_r  <= 16'h0000;
            data_wdata_r <= 16'h0000;
        end else if (take_s && sel_data_s) begin
            q_data_rdy   <= 1'b1;
        end else if (i_data_req && q_data_rdy) begin
            q_data_rdy   <= 1'b0;
            data_we_r    <= i_data_we;
            data_addr_r  <= i_data_addr;
            data_wdata_r <= i_data_wdata;
        end
    end

    // Memory request outputs: enables live only for the ISSUE cycle,
    // address and write data stay put until the next selection.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q_ce_fetch <= 1'b0;
            q_ce_alu   <= 1'b0;
            q_mem_we   <= 1'b0;
            q_mem_addr <= 16'h0000;
            q_mem_dina <= 16'h0000;
        end else begin
            q_ce_fetch <= take_s & ~sel_data_s;
            q_ce_alu   <= take_s & sel_data_s;
            q_mem_we   <= take_s & sel_data_s & data_we_r;
            if (take_s) begin
                q_mem_addr <= sel_data_s ? data_addr_r : fetch_addr_r;
                q_mem_dina <= sel_data_s ? data_wdata_r : 16'h0000;
            end
        end
    end

    // Response outputs: one-cycle pulses during RESP (or after a timeout)
    // and read words that hold until the next completion on their port.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q_fetch_valid <= 1'b0;
            q_data_done   <= 1'b0;
            q_err         <= 1'b0;
            q_busy        <= 1'b0;
            q_fetch_instr <= 16'h0000;
            q_data_rdata  <= 16'h0000;
        end else begin
            q_fetch_valid <= capture_s & ~sel_data_r;
            q_data_done   <= capture_s & sel_data_r;
            q_err         <= err_s;
            q_busy        <= (state_s != ST_IDLE);
            if (capture_s && !sel_data_r) begin
                q_fetch_instr <= i_mem_douta;
            end
            if (capture_s && sel_data_r) begin
                q_data_rdata <= i_mem_douta;
            end
        end
    end

endmodule

// File: tb/tb_prco_lmem_ctrl.sv
// Scoreboard bench for prco_lmem_ctrl: stimulus pushes expected words and
// arrival cycles into queues, a negedge monitor pops and compares them.
module tb_prco_lmem_ctrl;

    localparam int P_TIMEOUT = 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_fetch_req = 1'b0;
    logic [15:0] i_fetch_addr = 16'h0000;
    logic        q_fetch_rdy, q_fetch_valid;
    logic [15:0] q_fetch_instr;
    logic        i_data_req = 1'b0;
    logic        i_data_we = 1'b0;
    logic [15:0] i_data_addr = 16'h0000;
    logic [15:0] i_data_wdata = 16'h0000;
    logic        q_data_rdy, q_data_done;
    logic [15:0] q_data_rdata;
    logic        q_err, q_busy, q_ce_fetch, q_ce_alu, q_mem_we;
    logic [15:0] q_mem_addr, q_mem_dina;
    logic        i_ce_dec = 1'b0;
    logic        i_ce_reg = 1'b0;
    logic [15:0] i_mem_douta = 16'h0000;

    prco_lmem_ctrl #(.P_TIMEOUT(P_TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
        .q_fetch_rdy(q_fetch_rdy), .q_fetch_valid(q_fetch_valid), .q_fetch_instr(q_fetch_instr),
        .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
        .i_data_wdata(i_data_wdata), .q_data_rdy(q_data_rdy), .q_data_done(q_data_done),
        .q_data_rdata(q_data_rdata), .q_err(q_err), .q_busy(q_busy),
        .q_ce_fetch(q_ce_fetch), .q_ce_alu(q_ce_alu), .q_mem_we(q_mem_we),
        .q_mem_addr(q_mem_addr), .q_mem_dina(q_mem_dina),
        .i_ce_dec(i_ce_dec), .i_ce_reg(i_ce_reg), .i_mem_douta(i_mem_douta)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t q_f[$];
    exp_t q_d[$];
    int   q_e[$];
    int   vec_cnt = 0;
    int   miss_cnt = 0;
    int   cyc = 0;
    int   mem_mode = 0;   // 0 normal, 1 wrong strobe, 3 stray strobes every cycle
    logic [15:0] mem [0:255];

    // Cycle counter: number of rising edges seen so far.
    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory model: an enable seen at an edge is answered in the next cycle.
    always @(posedge i_clk) begin : mem_model
        logic        f, d, w;
        logic [15:0] a, wd;
        f = q_ce_fetch; d = q_ce_alu; w = q_mem_we; a = q_mem_addr; wd = q_mem_dina;
        #1;
        i_ce_dec = 1'b0;
        i_ce_reg = 1'b0;
        if (mem_mode == 3) begin
            i_ce_dec = 1'b1;
            i_ce_reg = 1'b1;
            i_mem_douta = 16'hFFFF;
        end else if (f || d) begin
            i_mem_douta = mem[a[7:0]];
            if (d && w) mem[a[7:0]] = wd;
            if (mem_mode == 0) begin
                i_ce_dec = f;
                i_ce_reg = d;
            end else if (mem_mode == 1) begin
                i_ce_dec = d;
                i_ce_reg = f;
            end
        end
    end

    // Monitor: every response pulse must match the head of its queue.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (q_fetch_valid === 1'b1) begin
            vec_cnt++;
            if (q_f.size() == 0) begin
                miss_cnt++;
                $display("FAIL fetch_valid: unexpected pulse at cycle %0d instr=%h", cyc, q_fetch_instr);
            end else begin
                e = q_f.pop_front();
                if (q_fetch_instr !== e.d || cyc != e.c) begin
                    miss_cnt++;
                    $display("FAIL fetch_valid: instr=%h cycle=%0d, expected instr=%h cycle=%0d",
                             q_fetch_instr, cyc, e.d, e.c);
                end
            end
        end
        if (q_data_done === 1'b1) begin
            vec_cnt++;
            if (q_d.size() == 0) begin
                miss_cnt++;
                $display("FAIL data_done: unexpected pulse at cycle %0d rdata=%h", cyc, q_data_rdata);
            end else begin
                e = q_d.pop_front();
                if (q_data_rdata !== e.d || cyc != e.c) begin
                    miss_cnt++;
                    $display("FAIL data_done: rdata=%h cycle=%0d, expected rdata=%h cycle=%0d",
                             q_data_rdata, cyc, e.d, e.c);
                end
            end
        end
        if (q_err === 1'b1) begin
            vec_cnt++;
            if (q_e.size() == 0) begin
                miss_cnt++;
                $display("FAIL err: unexpected pulse at cycle %0d", cyc);
            end else if (q_e[0] != cyc) begin
                miss_cnt++;
                $display("FAIL err: pulse at cycle %0d, expected cycle %0d", cyc, q_e.pop_front());
            end else begin
                void'(q_e.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fetch_rdy"}, 16'(q_fetch_rdy), 16'd1);
        chk({tag, "_data_rdy"}, 16'(q_data_rdy), 16'd1);
        chk({tag, "_pulses"}, {13'd0, q_fetch_valid, q_data_done, q_err}, 16'd0);
        chk({tag, "_enables"}, {12'd0, q_busy, q_ce_fetch, q_ce_alu, q_mem_we}, 16'd0);
        chk({tag, "_instr"}, q_fetch_instr, 16'h0000);
        chk({tag, "_rdata"}, q_data_rdata, 16'h0000);
        chk({tag, "_addr"}, q_mem_addr, 16'h0000);
        chk({tag, "_dina"}, q_mem_dina, 16'h0000);
    endtask

    // Bounded wait for all expectations to retire and the controller to go idle.
    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (q_f.size() == 0 && q_d.size() == 0 && q_e.size() == 0 &&
                q_busy === 1'b0 && q_fetch_rdy === 1'b1 && q_data_rdy === 1'b1)
                ok = 1'b1;
            else
                tick();
        end
        vec_cnt++;
        if (!ok) begin
            miss_cnt++;
            $display("FAIL %s: not drained, pending f=%0d d=%0d e=%0d busy=%b",
                     name, q_f.size(), q_d.size(), q_e.size(), q_busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[1]     = 16'h0B01;
        mem[2]     = 16'h2110;
        mem[8'haa] = 16'h00CA;
        mem[8'hab] = 16'h5A5A;

        // Reset state.
        #2 i_reset = 1'b0;
        #1 chk_reset("rst0");
        wait_cyc(2);
        i_reset = 1'b1;
        wait_cyc(2);

        // Fetch of 0x0002: enable for one cycle, valid three cycles after strobe.
        i_fetch_req = 1'b1; i_fetch_addr = 16'h0002;
        q_f.push_back('{16'h2110, cyc + 4});
        tick();
        i_fetch_req = 1'b0;
        tick();
        chk("ld_ce_fetch_on", {14'd0, q_ce_fetch, q_ce_alu}, 16'b10);
        chk("ld_mem_addr", q_mem_addr, 16'h0002);
        tick();
        chk("ld_ce_fetch_off", 16'(q_ce_fetch), 16'd0);
        drain("load");

        // Store 0x1234 to 0x00aa returns the old word 0x00CA.
        tick();
        i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 16'h00aa; i_data_wdata = 16'h1234;
        q_d.push_back('{16'h00CA, cyc + 4});
        tick();
        i_data_req = 1'b0; i_data_we = 1'b0;
        tick();
        chk("st_enables", {13'd0, q_ce_fetch, q_ce_alu, q_mem_we}, 16'b011);
        chk("st_addr", q_mem_addr, 16'h00aa);
        chk("st_dina", q_mem_dina, 16'h1234);
        tick();
        chk("st_wait_enables", {13'd0, q_ce_fetch, q_ce_alu, q_mem_we}, 16'b000);
        drain("store");

        // Load back 0x00aa.
        i_data_req = 1'b1; i_data_addr = 16'h00aa;
        q_d.push_back('{16'h1234, cyc + 4});
        tick();
        i_data_req = 1'b0;
        drain("load_back");
        chk("ld_back_held", q_data_rdata, 16'h1234);

        // Simultaneous strobes: data first, fetch valid four cycles after done.
        tick();
        i_fetch_req = 1'b1; i_fetch_addr = 16'h0001;
        i_data_req = 1'b1; i_data_addr = 16'h00ab;
        q_d.push_back('{16'h5A5A, cyc + 4});
        q_f.push_back('{16'h0B01, cyc + 8});
        tick();
        i_fetch_req = 1'b0; i_data_req = 1'b0;
        chk("sim_rdy_both_busy", {14'd0, q_fetch_rdy, q_data_rdy}, 16'b00);
        tick();
        chk("sim_alu_first", {14'd0, q_ce_fetch, q_ce_alu}, 16'b01);
        i_fetch_req = 1'b1; i_fetch_addr = 16'h0002;   // ignored: slot occupied
        tick();
        i_fetch_req = 1'b0;
        wait_cyc(2);
        chk("sim_fetch_rdy_low", 16'(q_fetch_rdy), 16'd0);
        tick();
        chk("sim_fetch_issue", {14'd0, q_ce_fetch, q_fetch_rdy}, 16'b11);
        chk("sim_fetch_addr", q_mem_addr, 16'h0001);
        drain("simultaneous");

        // Completion strobes while idle are ignored.
        mem_mode = 3;
        wait_cyc(4);
        mem_mode = 0;
        tick();
        chk("stray_busy", 16'(q_busy), 16'd0);
        chk("stray_instr", q_fetch_instr, 16'h0B01);
        chk("stray_rdata", q_data_rdata, 16'h5A5A);

`ifdef PRCO_LMEM_CTRL_TIMEOUT_EN
        // Wrong strobe during a data WAIT times out P_TIMEOUT cycles after entry.
        mem_mode = 1;
        tick();
        i_data_req = 1'b1; i_data_addr = 16'h00ab;
        q_e.push_back(cyc + 3 + P_TIMEOUT);
        tick();
        i_data_req = 1'b0;
        drain("timeout");
        chk("to_busy", 16'(q_busy), 16'd0);
        chk("to_rdata_kept", q_data_rdata, 16'h5A5A);
        mem_mode = 0;
`endif

        // Wrong strobe then reset during WAIT: access and pending fetch are lost.
        mem_mode = 1;
        tick();
        i_data_req = 1'b1; i_data_addr = 16'h00ab;
        tick();
        i_data_req = 1'b0;
        tick();
        i_fetch_req = 1'b1; i_fetch_addr = 16'h0002;
        tick();
        i_fetch_req = 1'b0;
        chk("rst_fetch_pending", 16'(q_fetch_rdy), 16'd0);
`ifndef PRCO_LMEM_CTRL_TIMEOUT_EN
        wait_cyc(12);
        chk("wrong_strobe_still_busy", 16'(q_busy), 16'd1);
`endif
        i_reset = 1'b0;
        #1 chk_reset("rst_mid");
        wait_cyc(2);
        mem_mode = 0;
        i_reset = 1'b1;
        wait_cyc(12);
        chk("post_rst_busy", 16'(q_busy), 16'd0);
        chk("post_rst_rdy", {14'd0, q_fetch_rdy, q_data_rdy}, 16'b11);

        chk("sb_empty", 16'(q_f.size() + q_d.size() + q_e.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/prco_lmem_ctrl.md
# prco_lmem_ctrl

Memory-side initiator for the PRCO on-chip local memory. It accepts single-cycle instruction-fetch and load/store request strobes from the core and arbitrates them onto the memory's single port. It drives the memory's fetch/ALU enable strobes, waits for the matching decode/register completion strobe, and returns the read word to the requester with a one-cycle done pulse. It sits between the fetch/ALU pipeline stages and the local memory block.

## Interface
Parameters:
- P_TIMEOUT, 8: cycles spent in WAIT without a matching completion strobe before the access is aborted; legal range 2..255.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_fetch_req  input  1  single-cycle fetch request strobe.
- i_fetch_addr  input  16  fetch address, sampled with i_fetch_req.
- q_fetch_rdy  output  1  fetch pending slot empty; a request may be issued.
- q_fetch_valid  output  1  one-cycle pulse; q_fetch_instr is valid.
- q_fetch_instr  output  16  fetched word, held until the next fetch completes.
- i_data_req  input  1  single-cycle load/store request strobe.
- i_data_we  input  1  1 = store, 0 = load; sampled with i_data_req.
- i_data_addr  input  16  data address.
- i_data_wdata  input  16  store data.
- q_data_rdy  output  1  data pending slot empty.
- q_data_done  output  1  one-cycle pulse; data access complete.
- q_data_rdata  output  16  load result, held until the next data access completes.
- q_err  output  1  one-cycle pulse; the access timed out.
- q_busy  output  1  state is not IDLE.
- q_ce_fetch  output  1  memory fetch enable.
- q_ce_alu  output  1  memory ALU-stage enable.
- q_mem_we  output  1  memory write enable.
- q_mem_addr  output  16  memory address.
- q_mem_dina  output  16  memory write data.
- i_ce_dec  input  1  memory completion strobe for fetch accesses.
- i_ce_reg  input  1  memory completion strobe for data accesses.
- i_mem_douta  input  16  memory read data; valid in the cycle a completion strobe is high.

## Operation
- Pending registers:
  - There is one pending entry per port, holding addr, plus we and wdata for the data port.
  - A request strobe is captured when its rdy is 1.
  - A strobe arriving while rdy is 0 is ignored; honouring rdy is the requester's obligation.
- State machine states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the data entry is pending, select data. Otherwise, if the fetch entry is pending, select fetch. A strobe arriving in IDLE is captured and then selected on the following edge. On selection, go to ISSUE, load q_mem_addr/q_mem_we/q_mem_dina from the entry, and clear the entry.
  - ISSUE: exactly one cycle. q_ce_fetch (fetch) or q_ce_alu (data) is 1. q_mem_we = 1 only for a store. Go to WAIT.
  - WAIT: all enables are 0. The matching strobe is i_ce_dec for fetch and i_ce_reg for data; a non-matching strobe is ignored. On the matching strobe, capture i_mem_douta into q_fetch_instr or q_data_rdata, then go to RESP.
  - RESP: pulse q_fetch_valid or q_data_done for one cycle, then go to IDLE.
- Store completion: q_data_rdata captures the pre-write contents of the address.
- Priority: when fetch and data strobes arrive in the same cycle, both are captured and data is served first.
- Back-to-back: each access occupies ISSUE + WAIT + RESP + IDLE, i.e. 4 cycles at minimum memory latency.
- Addresses pass through unmodified at 16 bits. The memory wraps or truncates them to its own depth; no arithmetic is performed here.

## Timing
- Request strobe at edge 0 (state IDLE, entry empty):
  - entry captured at edge 0;
  - ISSUE, with the enable high, during cycle 1–2;
  - memory strobe during cycle 2–3;
  - valid/done pulse during cycle 3–4.
- Request-to-done latency is 3 cycles plus any extra memory latency.
- Request outputs are registered; no input-to-output combinational path exists.
- Reset (i_reset = 0, asynchronous):
  - all outputs are forced to 0 (q_fetch_rdy = q_data_rdy = 1 once reset is applied);
  - state is IDLE and the pending entries are cleared.
- Reset mid-access aborts the access with no done/valid/err pulse; pending requests are lost.
- A completion strobe arriving outside WAIT is ignored.

## Configuration
- PRCO_LMEM_CTRL_TIMEOUT_EN defined:
  - An 8-bit WAIT counter is compiled in and cleared on entry to WAIT.
  - If it reaches P_TIMEOUT with no matching strobe, q_err pulses for one cycle and the state returns to IDLE.
  - On timeout, q_fetch_valid and q_data_done do not pulse, and the captured data registers are unchanged.
- PRCO_LMEM_CTRL_TIMEOUT_EN undefined: there is no counter, WAIT waits indefinitely, and q_err is tied to 0.

## Test plan
- Load: fetch strobe with addr 0x0002 while memory holds 0x2110 at that address -> q_ce_fetch high for exactly 1 cycle, q_fetch_valid high 3 cycles after the strobe, q_fetch_instr = 0x2110.
- Store then load: data strobe with we=1, addr 0x00aa, wdata 0x1234; after done, a load of 0x00aa -> q_data_rdata = 0x1234. The store's q_data_rdata equals the prior contents (0x00CA).
- Simultaneous strobes: fetch 0x0001 and data load 0x00ab in the same cycle -> the q_ce_alu access occurs first and done precedes valid by 4 cycles. During this, q_fetch_rdy = 0 until the fetch issues and a second fetch strobe is ignored.
- Wrong strobe: during a data WAIT, drive only i_ce_dec -> no done. With the macro defined and P_TIMEOUT=8, q_err pulses 8 cycles after WAIT entry and state returns to IDLE.
- Reset mid-op: assert i_reset low during WAIT -> all outputs 0 immediately, no done pulse after release, q_busy = 0, and both rdy = 1.
